junction_scheduler: RTL

Phase scheduler for a two-road junction with a pedestrian crossing. It latches car-detector and pedestrian requests and serves them round-robin. Green time is bounded by minimum and maximum dwell, and an emergency override is supported. It drives the junction lamps directly using the same 6-bit `lightseq` encoding as the fixed-sequence traffic light: bits [5:3] are road 1 R/A/G and bits [2:0] are road 2 R/A/G.

---
 rtl/junction_scheduler.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/junction_scheduler.sv
// junction_scheduler
//   Phase scheduler for a two-road junction with a pedestrian crossing.
//   Car-detector and push-button requests are latched into sticky flags and
//   served round-robin (road 1 -> road 2 -> ped). Green dwell is bounded by
//   GREEN_MIN / GREEN_MAX, and an emergency input can preempt service.
//   All timing is counted in ticks of TICK_DIV clock cycles.
//
// Ports
//   clock        in  1  system clock, rising edge
//   reset        in  1  synchronous, active-high
//   D1, D2       in  1  car detectors, road 1 / road 2 (level)
//   ped_req      in  1  pedestrian push-button (level or pulse)
//   emerg        in  1  emergency preemption active
//   emerg_road   in  1  preempting road (0 = road 1, 1 = road 2)
//   lightseq     out 6  [5:3] road 1 R/A/G, [2:0] road 2 R/A/G
//   walk         out 1  pedestrian walk lamp
//   req_pending  out 3  {ped, road2, road1} sticky request flags
module junction_scheduler #(
    parameter int TICK_DIV  = 50,
    parameter int ALLRED    = 1,
    parameter int PREP      = 1,
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 12,
    parameter int AMBER     = 2,
    parameter int WALK      = 6
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       D1,
    input  logic       D2,
    input  logic       ped_req,
    input  logic       emerg,
    input  logic       emerg_road,
    output logic [5:0] lightseq,
    output logic       walk,
    output logic [2:0] req_pending
);

    typedef enum logic [2:0] {
        S_ALLRED   = 3'd0,
        S_R1_PREP  = 3'd1,
        S_R1_GREEN = 3'd2,
        S_R1_AMBER = 3'd3,
        S_R2_PREP  = 3'd4,
        S_R2_GREEN = 3'd5,
        S_R2_AMBER = 3'd6,
        S_PED_WALK = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PH_R1  = 2'd0,
        PH_R2  = 2'd1,
        PH_PED = 2'd2
    } phase_t;

    // Dwell counts completed ticks, so a phase of N ticks ends when the tick
    // fires with dwell still at N-1.
    localparam logic [15:0] TICK_LAST   = 16'(TICK_DIV - 1);
    localparam logic [7:0]  ALLRED_LAST = 8'(ALLRED - 1);
    localparam logic [7:0]  PREP_LAST   = 8'(PREP - 1);
    localparam logic [7:0]  AMBER_LAST  = 8'(AMBER - 1);
    localparam logic [7:0]  WALK_LAST   = 8'(WALK - 1);
    localparam logic [8:0]  GMIN_T      = 9'(GREEN_MIN);
    localparam logic [8:0]  GMAX_T      = 9'(GREEN_MAX);

    state_t      state_q, state_d;
    phase_t      last_q, last_d;
    logic [15:0] presc_q, presc_d;
    logic [7:0]  dwell_q, dwell_d;
    logic        req1_q, req1_d;
    logic        req2_q, req2_d;
    logic        reqp_q, reqp_d;

    logic        tick;
    logic [8:0]  dwell_inc;
    state_t      arb_pick;
    logic        enter_r1g, enter_r2g, enter_walk;

    assign tick      = (presc_q == TICK_LAST);
    // Tick count including the tick completing on this edge; 9 bits so the
    // saturated value 255 still compares correctly.
    assign dwell_inc = {1'b0, dwell_q} + 9'd1;

    // Round-robin search starting at the phase after the last one served.
    always_comb begin
        arb_pick = S_R1_PREP;
        if (emerg) begin
            arb_pick = emerg_road ? S_R2_PREP : S_R1_PREP;
        end else begin
            case (last_q)
                PH_R1: begin
                    if (req2_q)      arb_pick = S_R2_PREP;
                    else if (reqp_q) arb_pick = S_PED_WALK;
                    else if (req1_q) arb_pick = S_R1_PREP;
                end
                PH_R2: begin
                    if (reqp_q)      arb_pick = S_PED_WALK;
                    else if (req1_q) arb_pick = S_R1_PREP;
                    else if (req2_q) arb_pick = S_R2_PREP;
                end
                default: begin
                    if (req1_q)      arb_pick = S_R1_PREP;
                    else if (req2_q) arb_pick = S_R2_PREP;
                    else if (reqp_q) arb_pick = S_PED_WALK;
                end
            endcase
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ALLRED:   if (tick && dwell_q == ALLRED_LAST) state_d = arb_pick;
            S_R1_PREP:  if (tick && dwell_q == PREP_LAST)   state_d = S_R1_GREEN;
            S_R1_GREEN: begin
                // Emergency overrides dwell limits in both directions: the
                // other road is cut immediately, the selected road rests.
                if (emerg) begin
                    if (emerg_road) state_d = S_R1_AMBER;
                end else if (tick && (req2_q || reqp_q) &&
                             (dwell_inc >= GMAX_T || (dwell_inc >= GMIN_T && !D1))) begin
                    state_d = S_R1_AMBER;
                end
            end
            S_R1_AMBER: if (tick && dwell_q == AMBER_LAST)  state_d = S_ALLRED;
            S_R2_PREP:  if (tick && dwell_q == PREP_LAST)   state_d = S_R2_GREEN;
            S_R2_GREEN: begin
                if (emerg) begin
                    if (!emerg_road) state_d = S_R2_AMBER;
                end else if (tick && (req1_q || reqp_q) &&
                             (dwell_inc >= GMAX_T || (dwell_inc >= GMIN_T && !D2))) begin
                    state_d = S_R2_AMBER;
                end
            end
            S_R2_AMBER: if (tick && dwell_q == AMBER_LAST)  state_d = S_ALLRED;
            S_PED_WALK: if (tick && dwell_q == WALK_LAST)   state_d = S_ALLRED;
            default:    state_d = S_ALLRED;
        endcase
    end

    assign enter_r1g  = (state_d == S_R1_GREEN) && (state_q != S_R1_GREEN);
    assign enter_r2g  = (state_d == S_R2_GREEN) && (state_q != S_R2_GREEN);
    assign enter_walk = (state_d == S_PED_WALK) && (state_q != S_PED_WALK);

    // Request flags, last-served phase and timers
    always_comb begin
        // Clearing on service entry takes priority over a coincident set.
        req1_d = (req1_q | (D1 & (state_q != S_R1_GREEN))) & ~enter_r1g;
        req2_d = (req2_q | (D2 & (state_q != S_R2_GREEN))) & ~enter_r2g;
        reqp_d = (reqp_q | (ped_req & (state_q != S_PED_WALK))) & ~enter_walk;

        last_d = last_q;
        if (enter_r1g)       last_d = PH_R1;
        else if (enter_r2g)  last_d = PH_R2;
        else if (enter_walk) last_d = PH_PED;

        presc_d = presc_q + 16'd1;
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            presc_d = 16'd0;
            dwell_d = 8'd0;
        end else if (tick) begin
            presc_d = 16'd0;
            if (dwell_q != 8'hFF) dwell_d = dwell_q + 8'd1;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_ALLRED;
            last_q  <= PH_PED;
            presc_q <= 16'd0;
            dwell_q <= 8'd0;
            req1_q  <= 1'b0;
            req2_q  <= 1'b0;
            reqp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            presc_q <= presc_d;
            dwell_q <= dwell_d;
            req1_q  <= req1_d;
            req2_q  <= req2_d;
            reqp_q  <= reqp_d;
        end
    end

    // Output decode of the registered state only
    always_comb begin
        lightseq = 6'b100100;
        walk     = 1'b0;
        case (state_q)
            S_ALLRED:   lightseq = 6'b100100;
            S_R1_PREP:  lightseq = 6'b110100;
            S_R1_GREEN: lightseq = 6'b001100;
            S_R1_AMBER: lightseq = 6'b010100;
            S_R2_PREP:  lightseq = 6'b100110;
            S_R2_GREEN: lightseq = 6'b100001;
            S_R2_AMBER: lightseq = 6'b100010;
            S_PED_WALK: begin
                lightseq = 6'b100100;
                walk     = 1'b1;
            end
            default:    lightseq = 6'b100100;
        endcase
        req_pending = {reqp_q, req2_q, req1_q};
    end

endmodule
